ds_pack: RTL and testbench

DS_PACK -- requirements
Module: ds_pack

---
 rtl/ds_pkg.sv | 30 +++
 rtl/ds_if.sv | 23 ++
 rtl/ds_pack_acc.sv | 96 +++++++++
 rtl/ds_pack.sv | 120 ++++++++++++
 tb/tb_ds_pack.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ds_pkg.sv
// ============================================================================
//  Module  : ds_pkg (package)
//  Purpose : Shared types and elaboration helpers for the ds_pack narrow-to-
//            wide stream packer.
//  Contents: RATIO legal range, packed-word / keep-mask types for the
//            default configuration (8-bit beats, RATIO = 4), and the
//            RATIO range-check function used at elaboration.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ds_pkg;

   localparam int unsigned RATIO_MIN = 2;
   localparam int unsigned RATIO_MAX = 16;

   // Default configuration: four 8-bit beats per output word.
   localparam int unsigned DEF_RATIO = 4;
   localparam int unsigned DEF_W     = 8;

   typedef logic [DEF_RATIO*DEF_W-1:0] word_t;
   typedef logic [DEF_RATIO-1:0]       keep_t;

   function automatic bit ratio_ok(input int unsigned r);
      return (r >= RATIO_MIN) && (r <= RATIO_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ds_if.sv
// ============================================================================
//  Module  : ds_if (interface)
//  Purpose : Valid/ready stream bundle with a typed payload.
//  Signals : vld  - source has a beat/word
//            rdy  - sink accepts it this cycle
//            data - payload of type T
//  Modports: master (drives vld/data), slave (drives rdy)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ds_if #(
   parameter type T = logic [7:0]
) ();
   logic vld;
   logic rdy;
   T     data;

   modport master (output vld, output data, input rdy);
   modport slave  (input vld, input data, output rdy);
endinterface

`default_nettype wire

// File: rtl/ds_pack_acc.sv
// ============================================================================
//  Module  : ds_pack_acc
//  Purpose : Slot register bank and beat counter of ds_pack. Stores accepted
//            beats in slot order and presents the completed word (current
//            beat merged in) in the same cycle the final beat is accepted.
//  Ports   : clk_i, rst_ni  - clock, async active-low reset
//            acc_i          - a beat is accepted this cycle
//            data_i         - beat payload
//            last_i         - beat closes the word early (DS_PACK_LAST_EN)
//            cnt_o          - beats held in the bank
//            done_o         - word completes this cycle
//            word_o         - completed word (valid with done_o)
//            keep_o         - slot-valid mask of word_o (DS_PACK_LAST_EN)
//  Config  : DS_PACK_LAST_EN enables last_i / keep_o.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ds_pack_acc
   import ds_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned RATIO = 4,
   parameter int unsigned CW    = $clog2(RATIO + 1)
) (
   input  wire logic                     clk_i,
   input  wire logic                     rst_ni,
   input  wire logic                     acc_i,
   input  wire logic [W-1:0]             data_i,
`ifdef DS_PACK_LAST_EN
   input  wire logic                     last_i,
   output logic      [RATIO-1:0]         keep_o,
`endif
   output logic      [CW-1:0]            cnt_o,
   output logic                          done_o,
   output logic      [RATIO-1:0][W-1:0]  word_o
);

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [RATIO-1:0][W-1:0] slot_q;
   logic                    w_last;

`ifdef DS_PACK_LAST_EN
   assign w_last = last_i;
`else
   assign w_last = 1'b0;
`endif

   assign cnt_o = cnt_q;

   always_comb begin
      done_o = acc_i && ((cnt_q == CW'(RATIO - 1)) || w_last);
      cnt_d  = cnt_q;
      if (acc_i) begin
         cnt_d = done_o ? '0 : cnt_q + CW'(1);
      end
      // Completed word = stored slots, current beat in slot cnt_q, and
      // zeros above it when the word is closed early.
      word_o = slot_q;
      for (int k = 0; k < int'(RATIO); k++) begin
         if (CW'(k) == cnt_q) begin
            word_o[k] = data_i;
         end else if (w_last && (CW'(k) > cnt_q)) begin
            word_o[k] = '0;
         end
      end
   end

`ifdef DS_PACK_LAST_EN
   always_comb begin
      keep_o = '0;
      for (int k = 0; k < int'(RATIO); k++) begin
         keep_o[k] = (CW'(k) <= cnt_q);
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         slot_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (acc_i) begin
            for (int k = 0; k < int'(RATIO); k++) begin
               if (CW'(k) == cnt_q) begin
                  slot_q[k] <= data_i;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ds_pack.sv
// ============================================================================
//  Module  : ds_pack
//  Purpose : Packs RATIO narrow input beats (type DTYPE) into one wide output
//            word, slot 0 in the LSBs. Registered output, one-cycle fill to
//            output latency, full throughput when the sink is ready.
//  Ports   : i_clk  - clock (rising edge)
//            i_rst  - asynchronous active-low reset
//            if_wr  - narrow input stream (ds_if slave)
//            if_rd  - packed output stream (ds_if master)
//            o_cnt  - beats currently held in the accumulator
//            i_last - close word early (DS_PACK_LAST_EN only)
//            o_keep - valid-slot mask, qualified by if_rd.vld
//                     (DS_PACK_LAST_EN only)
//  Config  : DS_PACK_LAST_EN adds i_last / o_keep.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ds_pack
   import ds_pkg::*;
#(
   parameter type         DTYPE = logic [7:0],
   parameter int unsigned RATIO = 4
) (
   input  wire logic                        i_clk,
   input  wire logic                        i_rst,
   ds_if.slave                              if_wr,
   ds_if.master                             if_rd,
   output logic [$clog2(RATIO + 1)-1:0]     o_cnt
`ifdef DS_PACK_LAST_EN
   ,
   input  wire logic                        i_last,
   output logic [RATIO-1:0]                 o_keep
`endif
);

   localparam int unsigned W  = $bits(DTYPE);
   localparam int unsigned CW = $clog2(RATIO + 1);
   localparam int unsigned WW = RATIO * W;

   if (!ratio_ok(RATIO)) begin : g_bad_ratio
      $fatal(1, "ds_pack: RATIO %0d outside legal range 2..16", RATIO);
   end

   logic                    w_wr_rdy;
   logic                    w_acc;
   logic                    w_done;
   logic [RATIO-1:0][W-1:0] w_word;
   logic                    vld_q, vld_d;
   logic [WW-1:0]           data_q, data_d;

   // Input may advance whenever the output register is free or draining.
   assign w_wr_rdy  = !vld_q || if_rd.rdy;
   assign w_acc     = if_wr.vld && w_wr_rdy;
   assign if_wr.rdy = w_wr_rdy;
   assign if_rd.vld = vld_q;
   assign if_rd.data = data_q;

`ifdef DS_PACK_LAST_EN
   logic [RATIO-1:0] w_keep;
   logic [RATIO-1:0] keep_q, keep_d;
   assign o_keep = keep_q;
`endif

   ds_pack_acc #(
      .W     (W),
      .RATIO (RATIO),
      .CW    (CW)
   ) u_acc (
      .clk_i  (i_clk),
      .rst_ni (i_rst),
      .acc_i  (w_acc),
      .data_i (if_wr.data),
`ifdef DS_PACK_LAST_EN
      .last_i (i_last),
      .keep_o (w_keep),
`endif
      .cnt_o  (o_cnt),
      .done_o (w_done),
      .word_o (w_word)
   );

   // A completing word takes priority over the drain so a simultaneous
   // handshake and fill replace the word without a bubble.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
`ifdef DS_PACK_LAST_EN
      keep_d = keep_q;
`endif
      if (w_done) begin
         vld_d  = 1'b1;
         data_d = w_word;
`ifdef DS_PACK_LAST_EN
         keep_d = w_keep;
`endif
      end else if (vld_q && if_rd.rdy) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
`ifdef DS_PACK_LAST_EN
         keep_q <= '0;
`endif
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
`ifdef DS_PACK_LAST_EN
         keep_q <= keep_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ds_pack.sv
// ============================================================================
//  Module  : tb_ds_pack
//  Purpose : Self-checking bench for ds_pack (RATIO = 4, 8-bit beats).
//            A queue-based packing model predicts the output register,
//            o_cnt and if_wr.rdy; directed sequences pin literal values.
//  Config  : DS_PACK_LAST_EN adds early-close stimulus and o_keep checks.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ds_pack;
   import ds_pkg::*;

   localparam int RATIO = int'(DEF_RATIO);
   localparam int W     = int'(DEF_W);

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] cnt;

   always #5 clk = ~clk;

   ds_if #(.T(logic [W-1:0])) wr_if ();
   ds_if #(.T(word_t))        rd_if ();

`ifdef DS_PACK_LAST_EN
   logic  last = 1'b0;
   keep_t keep;
`endif

   ds_pack #(
      .DTYPE (logic [W-1:0]),
      .RATIO (RATIO)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst_n),
      .if_wr  (wr_if.slave),
      .if_rd  (rd_if.master),
`ifdef DS_PACK_LAST_EN
      .i_last (last),
      .o_keep (keep),
`endif
      .o_cnt  (cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_beats[$];
   bit           m_vld  = 1'b0;
   word_t        m_data = '0;
   keep_t        m_keep = '0;
   int           words_made = 0;
   int           words_out  = 0;
   word_t        out_log[$];

   always @(negedge clk) begin
      bit wr_hs, rd_hs, close;
      if (!rst_n) begin
         m_beats.delete();
         m_vld  = 1'b0;
         m_data = '0;
         m_keep = '0;
      end else begin
         chk("rd_vld", 64'(rd_if.vld), 64'(m_vld));
         if (m_vld) chk("rd_data", 64'(rd_if.data), 64'(m_data));
         chk("o_cnt", 64'(cnt), 64'(m_beats.size()));
         chk("wr_rdy", 64'(wr_if.rdy), 64'(!m_vld || rd_if.rdy));
`ifdef DS_PACK_LAST_EN
         if (m_vld) chk("o_keep", 64'(keep), 64'(m_keep));
`endif
         wr_hs = wr_if.vld && (!m_vld || rd_if.rdy);
         rd_hs = m_vld && rd_if.rdy;
         if (rd_hs) begin
            out_log.push_back(rd_if.data);
            words_out++;
            m_vld = 1'b0;
         end
         if (wr_hs) begin
            m_beats.push_back(wr_if.data);
            close = (m_beats.size() == RATIO);
`ifdef DS_PACK_LAST_EN
            close = close || last;
`endif
            if (close) begin
               m_data = '0;
               for (int i = 0; i < m_beats.size(); i++) m_data[i*W +: W] = m_beats[i];
               m_keep = keep_t'((1 << m_beats.size()) - 1);
               m_vld  = 1'b1;
               words_made++;
               m_beats.delete();
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int  sent, cyc, base;
      bit  acc;
      wr_if.vld  = 1'b0;
      wr_if.data = '0;
      rd_if.rdy  = 1'b0;
      repeat (2) step();

      // Reset state
      chk("rst_vld", 64'(rd_if.vld), 64'(0));
      chk("rst_data", 64'(rd_if.data), 64'(0));
      chk("rst_cnt", 64'(cnt), 64'(0));
      rst_n = 1'b1;
      #1;
      chk("rdy_after_rst", 64'(wr_if.rdy), 64'(1));
      step();

      // Basic word, o_cnt 1,2,3,0
      rd_if.rdy = 1'b1;
      wr_if.vld = 1'b1;
      wr_if.data = 8'h11; step(); chk("cnt_seq1", 64'(cnt), 64'(1));
      wr_if.data = 8'h22; step(); chk("cnt_seq2", 64'(cnt), 64'(2));
      wr_if.data = 8'h33; step(); chk("cnt_seq3", 64'(cnt), 64'(3));
      wr_if.data = 8'h44; step(); chk("cnt_seq0", 64'(cnt), 64'(0));
      chk("word1_vld", 64'(rd_if.vld), 64'(1));
      chk("word1_data", 64'(rd_if.data), 64'(32'h44332211));
      wr_if.vld = 1'b0;
      step();
      chk("word1_drained", 64'(rd_if.vld), 64'(0));

      // 16 continuous beats
      base = out_log.size();
      wr_if.vld = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_if.data = 8'(i);
         #1 chk("cont_rdy", 64'(wr_if.rdy), 64'(1));
         step();
      end
      wr_if.vld = 1'b0;
      repeat (2) step();
      for (int j = 0; j < 4; j++) begin
         word_t e;
         e = 32'h03020100 + 32'(j) * 32'h04040404;
         chk("cont_word", (base + j < out_log.size()) ? 64'(out_log[base+j]) : 64'hdead, 64'(e));
      end

      // Output stall
      rd_if.rdy = 1'b0;
      wr_if.vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_if.data = 8'(8'h51 + i);
         step();
      end
      wr_if.data = 8'h99;
      for (int i = 0; i < 5; i++) begin
         chk("stall_rdy", 64'(wr_if.rdy), 64'(0));
         chk("stall_data", 64'(rd_if.data), 64'(32'h54535251));
         chk("stall_cnt", 64'(cnt), 64'(0));
         step();
      end
      rd_if.rdy = 1'b1;
      #1 chk("release_rdy", 64'(wr_if.rdy), 64'(1));
      step();
      wr_if.vld = 1'b0;
      chk("release_vld", 64'(rd_if.vld), 64'(0));
      chk("release_cnt", 64'(cnt), 64'(1));

      // Reset mid-word
      wr_if.vld = 1'b1;
      wr_if.data = 8'hAA; step();
      wr_if.data = 8'hBB; step();
      wr_if.vld = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_vld", 64'(rd_if.vld), 64'(0));
      chk("async_rst_cnt", 64'(cnt), 64'(0));
      chk("async_rst_data", 64'(rd_if.data), 64'(0));
      step();
      rst_n = 1'b1;
      step();
      wr_if.vld = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wr_if.data = 8'(i);
         step();
      end
      wr_if.vld = 1'b0;
      chk("post_rst_word", 64'(rd_if.data), 64'(32'h04030201));
      step();

`ifdef DS_PACK_LAST_EN
      wr_if.vld = 1'b1;
      wr_if.data = 8'h5A; step();
      wr_if.data = 8'h6B; last = 1'b1; step();
      last = 1'b0;
      wr_if.vld = 1'b0;
      chk("last_data", 64'(rd_if.data), 64'(32'h00006B5A));
      chk("last_keep", 64'(keep), 64'(4'b0011));
      wr_if.vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_if.data = 8'(8'hC0 + i);
         step();
      end
      wr_if.vld = 1'b0;
      chk("full_keep", 64'(keep), 64'(4'b1111));
      step();
`endif

      // Random traffic, 1000 beats
      sent = 0;
      cyc  = 0;
      while (sent < 1000 && cyc < 20000) begin
         rd_if.rdy = ($urandom_range(0, 3) != 0);
         if (!wr_if.vld && ($urandom_range(0, 3) != 0)) begin
            wr_if.vld  = 1'b1;
            wr_if.data = 8'($urandom);
         end
         @(negedge clk);
         acc = wr_if.vld && wr_if.rdy;
         step();
         cyc++;
         if (acc) begin
            sent++;
            wr_if.vld = 1'b0;
         end
      end
      wr_if.vld = 1'b0;
      chk("rand_budget", 64'(sent), 64'(1000));
      rd_if.rdy = 1'b1;
      repeat (3) step();
      chk("words_balanced", 64'(words_out), 64'(words_made));
      chk("drain_vld", 64'(rd_if.vld), 64'(0));
      chk("drain_cnt", 64'(cnt), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
